// File: rtl/dds_pkg.sv
// Shared DDS definitions: wave_sel encodings and the midscale helper.
// Used by the tick accumulator, its shaper and the prescaler benches.
package dds_pkg;

  localparam int unsigned WAVE_SEL_W = 2;

  localparam logic [WAVE_SEL_W-1:0] WAVE_SAW    = 2'b00;
  localparam logic [WAVE_SEL_W-1:0] WAVE_SQUARE = 2'b01;
  localparam logic [WAVE_SEL_W-1:0] WAVE_TRI    = 2'b10;
  localparam logic [WAVE_SEL_W-1:0] WAVE_RSVD   = 2'b11;

  // Unsigned midscale code 2^(w-1) for a w-bit sample.
  function automatic int unsigned midscale(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

endpackage

// File: rtl/dds_wave_shaper.sv
// Registered waveform shaper: turns the top OUT_W phase bits into a sample.
// Ports:
//   clock, reset   system clock, async active-high reset
//   i_load         capture a new sample this cycle
//   i_phase_top    top OUT_W bits of the phase accumulator
//   i_wave_sel     waveform select (saw/square/triangle/reserved)
//   o_sample       registered shaped sample, held between loads
module dds_wave_shaper
  import dds_pkg::*;
#(
  parameter int unsigned OUT_W = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [OUT_W-1:0]      i_phase_top,
  input  logic [WAVE_SEL_W-1:0] i_wave_sel,
  output logic [OUT_W-1:0]      o_sample
);

  logic             w_msb;
  logic [OUT_W-2:0] w_rest;
  logic [OUT_W-1:0] w_shaped;
  logic [OUT_W-1:0] r_sample;

  assign w_msb  = i_phase_top[OUT_W-1];
  assign w_rest = i_phase_top[OUT_W-2:0];

  // Triangle folds the second half of the cycle back down.
  always_comb begin
    w_shaped = OUT_W'(midscale(OUT_W));
    case (i_wave_sel)
      WAVE_SAW:    w_shaped = i_phase_top;
      WAVE_SQUARE: w_shaped = w_msb ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
      WAVE_TRI:    w_shaped = w_msb ? {~w_rest, 1'b0} : {w_rest, 1'b0};
      WAVE_RSVD:   w_shaped = OUT_W'(midscale(OUT_W));
      default:     w_shaped = OUT_W'(midscale(OUT_W));
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sample <= '0;
    end else if (i_load) begin
      r_sample <= w_shaped;
    end
  end

  assign o_sample = r_sample;

endmodule

// File: rtl/dds_tick_accumulator.sv
// DDS phase accumulator advanced by prescaler ticks, with a one-deep FCW
// staging slot and a registered waveform shaper behind it.
// Ports:
//   clock, reset          system clock, async active-high reset
//   enable                1 = ticks advance the phase
//   slow_clock            prescaler tick strobe (rising edge = tick)
//   fcw_data/valid/ready  frequency control word handshake into the pending slot
//   wave_sel              waveform select for the shaper
//   phase, wrap           accumulator value and carry-out pulse
//   sample, sample_valid  shaped sample and its 1-cycle update strobe
module dds_tick_accumulator
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned OUT_W   = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  slow_clock,
  input  logic [PHASE_W-1:0]    fcw_data,
  input  logic                  fcw_valid,
  output logic                  fcw_ready,
  input  logic [WAVE_SEL_W-1:0] wave_sel,
  output logic [PHASE_W-1:0]    phase,
  output logic                  wrap,
  output logic [OUT_W-1:0]      sample,
  output logic                  sample_valid
);

  logic               r_slow_q;
  logic               r_pend_full;
  logic [PHASE_W-1:0] r_pend_fcw;
  logic [PHASE_W-1:0] r_active_fcw;
  logic [PHASE_W-1:0] r_phase;
  logic               r_wrap;
  logic               r_tick_d;
  logic               r_sample_valid;

  logic               w_tick;
  logic               w_xfer;
  logic [PHASE_W:0]   w_sum;

  // Edge history follows slow_clock even when disabled, so a level that is
  // still high on re-enable does not produce a tick.
  assign w_tick = slow_clock & ~r_slow_q & enable;
  assign w_xfer = fcw_valid & ~r_pend_full;
  assign w_sum  = {1'b0, r_phase} + {1'b0, r_active_fcw};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_slow_q <= 1'b0;
    end else begin
      r_slow_q <= slow_clock;
    end
  end

  // Pending slot: a tick drains it, otherwise a handshake fills it. Both
  // cannot happen together because the slot only accepts while empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend_full  <= 1'b0;
      r_pend_fcw   <= '0;
      r_active_fcw <= '0;
    end else begin
      if (w_tick && r_pend_full) begin
        r_active_fcw <= r_pend_fcw;
        r_pend_full  <= 1'b0;
      end else if (w_xfer) begin
        r_pend_fcw  <= fcw_data;
        r_pend_full <= 1'b1;
      end
    end
  end

  // Accumulator steps with the word that was active before this tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_tick) begin
        r_phase <= w_sum[PHASE_W-1:0];
        r_wrap  <= w_sum[PHASE_W];
      end
    end
  end

  // Tick in N -> shaper loads in N+1 -> sample_valid in N+2.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tick_d       <= 1'b0;
      r_sample_valid <= 1'b0;
    end else begin
      r_tick_d       <= w_tick;
      r_sample_valid <= r_tick_d;
    end
  end

  dds_wave_shaper #(
    .OUT_W (OUT_W)
  ) u_shaper (
    .clock       (clock),
    .reset       (reset),
    .i_load      (r_tick_d),
    .i_phase_top (r_phase[PHASE_W-1 -: OUT_W]),
    .i_wave_sel  (wave_sel),
    .o_sample    (sample)
  );

  assign fcw_ready    = ~r_pend_full;
  assign phase        = r_phase;
  assign wrap         = r_wrap;
  assign sample_valid = r_sample_valid;

endmodule

// File: tb/tb_dds_tick_accumulator.sv
// Directed bench for dds_tick_accumulator at PHASE_W=16, OUT_W=8.
module tb_dds_tick_accumulator;

  localparam int unsigned PW = 16;
  localparam int unsigned OW = 8;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          slow_clock;
  logic [PW-1:0] fcw_data;
  logic          fcw_valid;
  logic          fcw_ready;
  logic [1:0]    wave_sel;
  logic [PW-1:0] phase;
  logic          wrap;
  logic [OW-1:0] sample;
  logic          sample_valid;

  int tests_run;
  int tests_failed;

  dds_tick_accumulator #(
    .PHASE_W (PW),
    .OUT_W   (OW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .slow_clock   (slow_clock),
    .fcw_data     (fcw_data),
    .fcw_valid    (fcw_valid),
    .fcw_ready    (fcw_ready),
    .wave_sel     (wave_sel),
    .phase        (phase),
    .wrap         (wrap),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    enable     = 1'b1;
    slow_clock = 1'b0;
    fcw_valid  = 1'b0;
    fcw_data   = '0;
    wave_sel   = 2'b00;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Single-cycle handshake into an empty pending slot.
  task automatic load_fcw(input logic [PW-1:0] w);
    fcw_data  = w;
    fcw_valid = 1'b1;
    step();
    fcw_valid = 1'b0;
  endtask

  // One slow_clock pulse followed by three idle clocks (4-clock tick period).
  task automatic do_tick(input logic [PW-1:0] ep, input logic ew,
                         input logic [OW-1:0] es, input bit drop_valid);
    slow_clock = 1'b1;
    step();
    slow_clock = 1'b0;
    if (drop_valid) fcw_valid = 1'b0;
    tests_run++;
    if (phase !== ep) begin
      tests_failed++;
      $display("FAIL tick_phase: got %h expected %h", phase, ep);
    end
    tests_run++;
    if (wrap !== ew) begin
      tests_failed++;
      $display("FAIL tick_wrap: got %b expected %b (phase %h)", wrap, ew, ep);
    end
    tests_run++;
    if (sample_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_valid: got %b expected 0", sample_valid);
    end
    step();
    tests_run++;
    if (sample_valid !== 1'b1 || sample !== es) begin
      tests_failed++;
      $display("FAIL tick_sample: valid %b sample %h expected valid 1 sample %h",
               sample_valid, sample, es);
    end
    tests_run++;
    if (wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_width: got %b expected 0", wrap);
    end
    step();
    tests_run++;
    if (sample_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL valid_width: got %b expected 0", sample_valid);
    end
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (phase !== 16'h0000 || wrap !== 1'b0 || sample !== 8'h00 ||
        sample_valid !== 1'b0 || fcw_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: phase %h wrap %b sample %h valid %b ready %b expected 0 0 0 0 1",
               phase, wrap, sample, sample_valid, fcw_ready);
    end
  endtask

  task automatic test_basic_step();
    load_fcw(16'h1000);
    tests_run++;
    if (fcw_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ready_after_load: got %b expected 0", fcw_ready);
    end
    step();
    tests_run++;
    if (fcw_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ready_before_tick: got %b expected 0", fcw_ready);
    end
    do_tick(16'h0000, 1'b0, 8'h00, 1'b0);
    tests_run++;
    if (fcw_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_after_tick: got %b expected 1", fcw_ready);
    end
    do_tick(16'h1000, 1'b0, 8'h10, 1'b0);
    do_tick(16'h2000, 1'b0, 8'h20, 1'b0);
  endtask

  task automatic test_wrap();
    apply_reset();
    load_fcw(16'h4000);
    do_tick(16'h0000, 1'b0, 8'h00, 1'b0);
    do_tick(16'h4000, 1'b0, 8'h40, 1'b0);
    do_tick(16'h8000, 1'b0, 8'h80, 1'b0);
    do_tick(16'hC000, 1'b0, 8'hC0, 1'b0);
    do_tick(16'h0000, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_held_high();
    int valid_cnt;
    valid_cnt = 0;
    slow_clock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sample_valid === 1'b1) valid_cnt++;
    end
    slow_clock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (sample_valid === 1'b1) valid_cnt++;
    end
    tests_run++;
    if (phase !== 16'h4000) begin
      tests_failed++;
      $display("FAIL held_phase: got %h expected 4000", phase);
    end
    tests_run++;
    if (valid_cnt != 1) begin
      tests_failed++;
      $display("FAIL held_valid_count: got %0d expected 1", valid_cnt);
    end
  endtask

  task automatic test_back_to_back_fcw();
    apply_reset();
    fcw_data  = 16'h0100;
    fcw_valid = 1'b1;
    step();
    fcw_data = 16'h0200;
    step();
    tests_run++;
    if (fcw_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL holdoff_ready: got %b expected 0", fcw_ready);
    end
    do_tick(16'h0000, 1'b0, 8'h00, 1'b0);
    fcw_valid = 1'b0;
    tests_run++;
    if (fcw_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL second_transfer: ready %b expected 0", fcw_ready);
    end
    do_tick(16'h0100, 1'b0, 8'h01, 1'b0);
    do_tick(16'h0300, 1'b0, 8'h03, 1'b0);
    tests_run++;
    if (fcw_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL drained_ready: got %b expected 1", fcw_ready);
    end
    fcw_data  = 16'h0010;
    fcw_valid = 1'b1;
    do_tick(16'h0500, 1'b0, 8'h05, 1'b1);
    tests_run++;
    if (fcw_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL coincident_pending: ready %b expected 0", fcw_ready);
    end
    do_tick(16'h0700, 1'b0, 8'h07, 1'b0);
    do_tick(16'h0710, 1'b0, 8'h07, 1'b0);
  endtask

  task automatic test_shapes();
    apply_reset();
    load_fcw(16'h4000);
    do_tick(16'h0000, 1'b0, 8'h00, 1'b0);
    do_tick(16'h4000, 1'b0, 8'h40, 1'b0);
    do_tick(16'h8000, 1'b0, 8'h80, 1'b0);
    load_fcw(16'h0000);
    do_tick(16'hC000, 1'b0, 8'hC0, 1'b0);
    wave_sel = 2'b00;
    do_tick(16'hC000, 1'b0, 8'hC0, 1'b0);
    wave_sel = 2'b01;
    do_tick(16'hC000, 1'b0, 8'hFF, 1'b0);
    wave_sel = 2'b10;
    do_tick(16'hC000, 1'b0, 8'h7E, 1'b0);
    wave_sel = 2'b11;
    do_tick(16'hC000, 1'b0, 8'h80, 1'b0);
    wave_sel = 2'b00;
  endtask

  task automatic test_enable_and_reset();
    int valid_cnt;
    apply_reset();
    load_fcw(16'h1000);
    do_tick(16'h0000, 1'b0, 8'h00, 1'b0);
    do_tick(16'h1000, 1'b0, 8'h10, 1'b0);
    enable = 1'b0;
    load_fcw(16'h0800);
    tests_run++;
    if (fcw_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL disabled_accept: ready %b expected 0", fcw_ready);
    end
    valid_cnt = 0;
    for (int t = 0; t < 3; t++) begin
      slow_clock = 1'b1;
      step();
      if (sample_valid === 1'b1) valid_cnt++;
      slow_clock = 1'b0;
      for (int i = 0; i < 3; i++) begin
        step();
        if (sample_valid === 1'b1) valid_cnt++;
      end
    end
    tests_run++;
    if (phase !== 16'h1000 || valid_cnt != 0) begin
      tests_failed++;
      $display("FAIL frozen: phase %h valids %0d expected 1000 and 0", phase, valid_cnt);
    end
    enable = 1'b1;
    step();
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (phase !== 16'h0000 || wrap !== 1'b0 || sample !== 8'h00 ||
        sample_valid !== 1'b0 || fcw_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrun_reset: phase %h wrap %b sample %h valid %b ready %b expected 0 0 0 0 1",
               phase, wrap, sample, sample_valid, fcw_ready);
    end
    step();
    reset = 1'b0;
    step();
    do_tick(16'h0000, 1'b0, 8'h00, 1'b0);
    do_tick(16'h0000, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    enable       = 1'b1;
    slow_clock   = 1'b0;
    fcw_valid    = 1'b0;
    fcw_data     = '0;
    wave_sel     = 2'b00;
    test_reset();
    test_basic_step();
    test_wrap();
    test_held_high();
    test_back_to_back_fcw();
    test_shapes();
    test_enable_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
